// File: rtl/ex_stage_if.sv
// ID/EX, hazard, writeback and EX/MEM signal bundle for the execute stage.
// The slave side is the execute stage; the master side is the surrounding pipeline.
interface ex_stage_if;
  logic [1:0] WBreg;
  logic [1:0] Mreg;
  logic [1:0] EXreg;
  logic [7:0] DataAreg;
  logic [7:0] DataBreg;
  logic [7:0] imm_valuereg;
  logic       RegRsreg;
  logic       RegRtreg;

  logic       id_rs;
  logic       id_rt;
  logic       flush;

  logic       memwb_regwrite;
  logic       memwb_rd;
  logic [7:0] memwb_data;

  logic [1:0] WB_exmem;
  logic [1:0] M_exmem;
  logic [7:0] alu_exmem;
  logic [7:0] store_exmem;
  logic       rd_exmem;
  logic       zero_exmem;
  logic       carry_exmem;
  logic       stall_req;

  modport slave (
    input  WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg, RegRsreg, RegRtreg,
    input  id_rs, id_rt, flush,
    input  memwb_regwrite, memwb_rd, memwb_data,
    output WB_exmem, M_exmem, alu_exmem, store_exmem, rd_exmem, zero_exmem, carry_exmem,
    output stall_req
  );

  modport master (
    output WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg, RegRsreg, RegRtreg,
    output id_rs, id_rt, flush,
    output memwb_regwrite, memwb_rd, memwb_data,
    input  WB_exmem, M_exmem, alu_exmem, store_exmem, rd_exmem, zero_exmem, carry_exmem,
    input  stall_req
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding (FORWARDING_EN), 8-bit add/sub ALU, load-use stall request.
// Latency 1 cycle into EX/MEM; no backpressure, stall_req only asks upstream to freeze and bubble.
module ex_stage (
  input  logic       clock,
  input  logic       reset,
  ex_stage_if.slave  bus
);
  logic [7:0] op_a;
  logic [7:0] fwd_b;
  logic [7:0] alu_b;
  logic [8:0] sum;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic       rt_match;
  logic       hazard;

`ifdef FORWARDING_EN
  logic exmem_fwd_ok;

  // A load's EX/MEM result is not yet data, so only non-load writers forward from EX/MEM.
  assign exmem_fwd_ok = bus.WB_exmem[1] & ~bus.M_exmem[1];

  always_comb begin
    op_a  = bus.DataAreg;
    fwd_b = bus.DataBreg;
    if (exmem_fwd_ok && (bus.rd_exmem == bus.RegRsreg))
      op_a = bus.alu_exmem;
    else if (bus.memwb_regwrite && (bus.memwb_rd == bus.RegRsreg))
      op_a = bus.memwb_data;
    if (exmem_fwd_ok && (bus.rd_exmem == bus.RegRtreg))
      fwd_b = bus.alu_exmem;
    else if (bus.memwb_regwrite && (bus.memwb_rd == bus.RegRtreg))
      fwd_b = bus.memwb_data;
  end
`else
  logic unused_fwd;

  assign op_a       = bus.DataAreg;
  assign fwd_b      = bus.DataBreg;
  assign unused_fwd = ^{bus.memwb_regwrite, bus.memwb_rd, bus.memwb_data, bus.M_exmem};
`endif

  always_comb begin
    alu_b     = bus.EXreg[1] ? bus.imm_valuereg : fwd_b;
    sum       = bus.EXreg[0] ? ({1'b0, op_a} - {1'b0, alu_b}) : ({1'b0, op_a} + {1'b0, alu_b});
    alu_res   = sum[7:0];
    alu_carry = bus.EXreg[0] ? (op_a >= alu_b) : sum[8];
  end

  assign rt_match = (bus.RegRtreg == bus.id_rs) || (bus.RegRtreg == bus.id_rt);

`ifdef FORWARDING_EN
  assign hazard = bus.Mreg[1] & rt_match;
`else
  // Without forwarding every in-flight writer in ID/EX or EX/MEM must drain before ID reads.
  assign hazard = (bus.Mreg[1] & rt_match) | (bus.WBreg[1] & rt_match) |
                  (bus.WB_exmem[1] & ((bus.rd_exmem == bus.id_rs) || (bus.rd_exmem == bus.id_rt)));
`endif

  assign bus.stall_req = ~bus.flush & hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.WB_exmem    <= 2'b00;
      bus.M_exmem     <= 2'b00;
      bus.alu_exmem   <= 8'h00;
      bus.store_exmem <= 8'h00;
      bus.rd_exmem    <= 1'b0;
      bus.zero_exmem  <= 1'b0;
      bus.carry_exmem <= 1'b0;
    end else begin
      bus.WB_exmem    <= bus.flush ? 2'b00 : bus.WBreg;
      bus.M_exmem     <= bus.flush ? 2'b00 : bus.Mreg;
      bus.alu_exmem   <= alu_res;
      bus.store_exmem <= fwd_b;
      bus.rd_exmem    <= bus.RegRtreg;
      bus.zero_exmem  <= (alu_res == 8'h00);
      bus.carry_exmem <= alu_carry;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ex_stage_if bus();

  ex_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Model of what the EX/MEM register should hold.
  logic [1:0] m_wb, m_m;
  logic [7:0] m_alu, m_store;
  logic       m_rd, m_zero, m_carry;

  function automatic logic [7:0] operand(input logic id, input logic [7:0] dat);
`ifdef FORWARDING_EN
    if (m_wb[1] && !m_m[1] && m_rd == id) return m_alu;
    if (bus.memwb_regwrite && bus.memwb_rd == id) return bus.memwb_data;
`endif
    return dat;
  endfunction

  function automatic logic [22:0] model_next();
    int a, b, r;
    logic c;
    logic [7:0] fb;
    a  = int'(operand(bus.RegRsreg, bus.DataAreg));
    fb = operand(bus.RegRtreg, bus.DataBreg);
    b  = bus.EXreg[1] ? int'(bus.imm_valuereg) : int'(fb);
    if (bus.EXreg[0]) begin
      r = (a - b + 256) % 256;
      c = (a >= b);
    end else begin
      r = (a + b) % 256;
      c = (a + b) > 255;
    end
    return {bus.flush ? 2'b00 : bus.WBreg, bus.flush ? 2'b00 : bus.Mreg,
            8'(r), fb, bus.RegRtreg, (r == 0), c};
  endfunction

  function automatic logic model_stall();
    logic hz;
    hz = bus.Mreg[1] && (bus.RegRtreg == bus.id_rs || bus.RegRtreg == bus.id_rt);
`ifndef FORWARDING_EN
    if (bus.WBreg[1] && (bus.RegRtreg == bus.id_rs || bus.RegRtreg == bus.id_rt)) hz = 1'b1;
    if (m_wb[1] && (m_rd == bus.id_rs || m_rd == bus.id_rt)) hz = 1'b1;
`endif
    return !bus.flush && hz;
  endfunction

  function automatic logic [22:0] observed();
    return {bus.WB_exmem, bus.M_exmem, bus.alu_exmem, bus.store_exmem,
            bus.rd_exmem, bus.zero_exmem, bus.carry_exmem};
  endfunction

  task automatic clear_model();
    {m_wb, m_m, m_alu, m_store, m_rd, m_zero, m_carry} = 23'h0;
  endtask

  task automatic clear_inputs();
    bus.WBreg = 2'b00; bus.Mreg = 2'b00; bus.EXreg = 2'b00;
    bus.DataAreg = 8'h00; bus.DataBreg = 8'h00; bus.imm_valuereg = 8'h00;
    bus.RegRsreg = 1'b0; bus.RegRtreg = 1'b0;
    bus.id_rs = 1'b0; bus.id_rt = 1'b0; bus.flush = 1'b0;
    bus.memwb_regwrite = 1'b0; bus.memwb_rd = 1'b0; bus.memwb_data = 8'h00;
  endtask

  // Predict, clock once, sample 1 time unit after the edge and advance the model.
  task automatic step(output logic [22:0] exp);
    exp = model_next();
    @(posedge clock);
    #1;
    {m_wb, m_m, m_alu, m_store, m_rd, m_zero, m_carry} = exp;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    clear_model();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    clear_model();
    #1 reset = 1'b1;
    #2;
    checks++;
    if (observed() !== 23'h0) begin
      failures++;
      $display("FAIL reset_async got=%h want=%h", observed(), 23'h0);
    end
    bus.WBreg = 2'b11; bus.Mreg = 2'b11; bus.DataAreg = 8'h5A; bus.RegRtreg = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (observed() !== 23'h0) begin
      failures++;
      $display("FAIL reset_held_edge got=%h want=%h", observed(), 23'h0);
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_add();
    logic [22:0] exp;
    pulse_reset();
    bus.DataAreg = 8'h12; bus.DataBreg = 8'h05; bus.EXreg = 2'b00; bus.WBreg = 2'b10;
    step(exp);
    checks++;
    if (bus.alu_exmem !== 8'h17 || bus.carry_exmem !== 1'b0 || bus.zero_exmem !== 1'b0 ||
        bus.WB_exmem !== 2'b10) begin
      failures++;
      $display("FAIL add_basic got alu=%h c=%b z=%b wb=%b want alu=17 c=0 z=0 wb=10",
               bus.alu_exmem, bus.carry_exmem, bus.zero_exmem, bus.WB_exmem);
    end
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL add_model got=%h want=%h", observed(), exp);
    end
  endtask

  task automatic test_wrap_zero();
    logic [22:0] exp;
    pulse_reset();
    bus.DataAreg = 8'hFF; bus.imm_valuereg = 8'h01; bus.EXreg = 2'b10;
    step(exp);
    checks++;
    if (bus.alu_exmem !== 8'h00 || bus.zero_exmem !== 1'b1 || bus.carry_exmem !== 1'b1) begin
      failures++;
      $display("FAIL add_wrap got alu=%h z=%b c=%b want alu=00 z=1 c=1",
               bus.alu_exmem, bus.zero_exmem, bus.carry_exmem);
    end
    pulse_reset();
    bus.DataAreg = 8'h05; bus.DataBreg = 8'h05; bus.EXreg = 2'b01;
    step(exp);
    checks++;
    if (bus.alu_exmem !== 8'h00 || bus.zero_exmem !== 1'b1 || bus.carry_exmem !== 1'b1) begin
      failures++;
      $display("FAIL sub_equal got alu=%h z=%b c=%b want alu=00 z=1 c=1",
               bus.alu_exmem, bus.zero_exmem, bus.carry_exmem);
    end
    pulse_reset();
    bus.DataAreg = 8'h03; bus.DataBreg = 8'h05; bus.EXreg = 2'b01;
    step(exp);
    checks++;
    if (bus.alu_exmem !== 8'hFE || bus.carry_exmem !== 1'b0 || bus.zero_exmem !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow got alu=%h c=%b z=%b want alu=fe c=0 z=0",
               bus.alu_exmem, bus.carry_exmem, bus.zero_exmem);
    end
  endtask

  task automatic test_forward();
    logic [22:0] exp;
    logic [7:0]  want;
    pulse_reset();
    bus.DataAreg = 8'h30; bus.WBreg = 2'b10; bus.RegRtreg = 1'b1;
    step(exp);
    clear_inputs();
    bus.memwb_rd = 1'b1; bus.memwb_data = 8'h40; bus.memwb_regwrite = 1'b1;
    bus.RegRsreg = 1'b1; bus.RegRtreg = 1'b0; bus.DataAreg = 8'h01; bus.DataBreg = 8'h02;
`ifdef FORWARDING_EN
    want = 8'h32;
`else
    want = 8'h03;
`endif
    step(exp);
    checks++;
    if (bus.alu_exmem !== want) begin
      failures++;
      $display("FAIL forward_priority got alu=%h want=%h", bus.alu_exmem, want);
    end
  endtask

  task automatic test_load_use();
    logic [22:0] exp;
    pulse_reset();
    bus.Mreg = 2'b10; bus.WBreg = 2'b11; bus.RegRtreg = 1'b0; bus.id_rs = 1'b0; bus.id_rt = 1'b1;
    #1;
    checks++;
    if (bus.stall_req !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall got=%b want=1", bus.stall_req);
    end
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_kills_stall got=%b want=0", bus.stall_req);
    end
    step(exp);
    checks++;
    if (bus.WB_exmem !== 2'b00 || bus.M_exmem !== 2'b00) begin
      failures++;
      $display("FAIL flush_bubble got wb=%b m=%b want 00 00", bus.WB_exmem, bus.M_exmem);
    end
  endtask

  task automatic test_async_reset();
    logic [22:0] exp;
    pulse_reset();
    bus.DataAreg = 8'h12; bus.DataBreg = 8'h05; bus.WBreg = 2'b10; bus.Mreg = 2'b01;
    bus.RegRtreg = 1'b1;
    step(exp);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (observed() !== 23'h0) begin
      failures++;
      $display("FAIL mid_reset_clear got=%h want=%h", observed(), 23'h0);
    end
    reset = 1'b0;
    clear_model();
    bus.DataAreg = 8'h20; bus.DataBreg = 8'h01; bus.EXreg = 2'b01;
    step(exp);
    checks++;
    if (observed() !== exp || bus.alu_exmem !== 8'h1F) begin
      failures++;
      $display("FAIL reset_resume got=%h want=%h", observed(), exp);
    end
  endtask

  task automatic test_noforward_stall();
    logic [22:0] exp;
    logic        want;
    pulse_reset();
    bus.WBreg = 2'b10; bus.RegRtreg = 1'b1;
    step(exp);
    clear_inputs();
    bus.id_rt = 1'b1; bus.id_rs = 1'b0; bus.RegRtreg = 1'b0;
    #1;
`ifdef FORWARDING_EN
    want = 1'b0;
`else
    want = 1'b1;
`endif
    checks++;
    if (bus.stall_req !== want) begin
      failures++;
      $display("FAIL exmem_writer_stall got=%b want=%b", bus.stall_req, want);
    end
  endtask

  task automatic test_random();
    logic [22:0] exp, mask;
    logic        ws;
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      bus.WBreg = 2'($urandom); bus.Mreg = 2'($urandom); bus.EXreg = 2'($urandom);
      bus.DataAreg = 8'($urandom); bus.DataBreg = 8'($urandom); bus.imm_valuereg = 8'($urandom);
      bus.RegRsreg = 1'($urandom); bus.RegRtreg = 1'($urandom);
      bus.id_rs = 1'($urandom); bus.id_rt = 1'($urandom);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.memwb_regwrite = 1'($urandom); bus.memwb_rd = 1'($urandom);
      bus.memwb_data = 8'($urandom);
      #1;
      ws = model_stall();
      checks++;
      if (bus.stall_req !== ws) begin
        failures++;
        $display("FAIL rand_stall[%0d] got=%b want=%b", i, bus.stall_req, ws);
      end
      mask = bus.flush ? 23'h780000 : 23'h7FFFFF;
      step(exp);
      checks++;
      if ((observed() & mask) !== (exp & mask)) begin
        failures++;
        $display("FAIL rand_exmem[%0d] got=%h want=%h", i, observed() & mask, exp & mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap_zero();
    test_forward();
    test_load_use();
    test_async_reset();
    test_noforward_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clock input 1 (rising edge), reset input 1 (async, active-high).
REQ-002 ID/EX side SHALL be: WBreg in 2 ([1]=RegWrite, [0]=MemtoReg); Mreg in 2 ([1]=MemRead, [0]=MemWrite); EXreg in 2 ([1]=ALUSrc imm, [0]=ALUOp 0 add/1 sub); DataAreg, DataBreg, imm_valuereg in 8 each; RegRsreg, RegRtreg in 1 each (RegRtreg = destination).
REQ-003 Decode-side hazard inputs SHALL be: id_rs in 1, id_rt in 1 (register IDs of the instruction currently in ID); flush in 1 (branch taken, kill instruction in EX).
REQ-004 Writeback-side inputs SHALL be: memwb_regwrite in 1, memwb_rd in 1, memwb_data in 8.
REQ-005 EX/MEM outputs SHALL be: WB_exmem out 2, M_exmem out 2, alu_exmem out 8, store_exmem out 8, rd_exmem out 1, zero_exmem out 1, carry_exmem out 1.
REQ-006 Control output SHALL be stall_req out 1 (combinational; freeze PC/IFID, bubble ID/EX).

Function
REQ-007 Operand A SHALL be: EX/MEM forward if WB_exmem[1]=1, M_exmem[1]=0, rd_exmem=RegRsreg; else MEM/WB forward if memwb_regwrite=1 and memwb_rd=RegRsreg; else DataAreg.
REQ-008 Forwarded B SHALL use the REQ-007 rule with RegRtreg and DataBreg; EX/MEM SHALL take priority over MEM/WB when both match.
REQ-009 ALU B input SHALL be imm_valuereg when EXreg[1]=1, else forwarded B.
REQ-010 ALU SHALL compute A+B (ALUOp=0) or A-B (ALUOp=1), 8-bit wrap-around; carry = bit 8 of the 9-bit sum, or borrow-free flag (A>=B) for subtract; zero = (result==0).
REQ-011 On each rising clock edge the EX/MEM register SHALL load WB, M, ALU result, forwarded B (store_exmem), RegRtreg, zero and carry; latency ID/EX to EX/MEM is exactly 1 cycle.
REQ-012 When flush=1 at the edge, WB_exmem and M_exmem SHALL load 2'b00 (bubble); data fields load normally and are don't-care.
REQ-013 stall_req SHALL be 1 when Mreg[1]=1 and RegRtreg equals id_rs or id_rt (load-use); flush=1 SHALL force stall_req=0.
REQ-014 The block SHALL NOT gate its own register on stall_req; the upstream ID/EX bubble arrives as WBreg=Mreg=0.
REQ-015 The register file is write-first; the MEM/WB stage therefore SHALL NOT raise a stall.

Reset
REQ-016 reset=1 SHALL asynchronously clear every EX/MEM output (WB_exmem, M_exmem, alu_exmem, store_exmem, rd_exmem, zero_exmem, carry_exmem) to 0.
REQ-017 Reset asserted mid-operation SHALL discard the in-flight instruction; the first edge after deassertion loads the current ID/EX inputs.
REQ-018 stall_req SHALL be combinational and depend only on its inputs, including during reset.

Configuration
REQ-019 With macro FORWARDING_EN defined, REQ-007/008 forwarding SHALL be present.
REQ-020 Without FORWARDING_EN, operands SHALL be DataAreg/DataBreg directly, and stall_req SHALL additionally be 1 when WBreg[1]=1 and RegRtreg matches id_rs or id_rt, or WB_exmem[1]=1 and rd_exmem matches id_rs or id_rt (flush still forces 0).

Verification
REQ-021 Add, no hazard: DataA=8'h12, DataB=8'h05, EX=00, WB=10 -> next edge alu_exmem=8'h17, carry=0, zero=0, WB_exmem=10.
REQ-022 Wrap/zero: DataA=8'hFF, imm=8'h01, EX=10 -> alu_exmem=8'h00, zero=1, carry=1; subtract 8'h05-8'h05 -> zero=1, carry=1.
REQ-023 Forward priority (FORWARDING_EN): rd_exmem=1, alu_exmem=8'h30, WB_exmem=10; memwb_rd=1, memwb_data=8'h40, memwb_regwrite=1; RegRsreg=1, DataA=8'h01, DataB=8'h02 add -> alu_exmem=8'h32.
REQ-024 Load-use: Mreg=10, RegRtreg=0, id_rs=0 -> stall_req=1 same cycle; same with flush=1 -> stall_req=0 and next WB_exmem=M_exmem=00.
REQ-025 Async reset: assert reset between edges with alu_exmem=8'h17 -> all EX/MEM outputs 0 before the next edge; deassert -> normal loading resumes.
REQ-026 No FORWARDING_EN: WB_exmem=10, rd_exmem=1, id_rt=1, Mreg=00, WBreg=00 -> stall_req=1.
